avg_sink: RTL and testbench
===========================

# avg_sink

Result sink for the 12-sample average-nearest filter. It captures every 16-bit filter output presented while `ready` is high, buffers the samples in a DEPTH-entry circular FIFO, and delivers them to a downstream consumer through a valid/ack read handshake. It also keeps sticky overflow status and the running minimum and maximum of all accepted samples. It sits directly after the filter and replaces ad-hoc capture logic in the top level.

## Interface
- DW, 16, sample width
- DEPTH, 16, FIFO entries; power of two, at least 2
- AW, log2(DEPTH), pointer width (derived)
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- ready  in  1  upstream sample-valid; high = `din` holds a new result this cycle
- din  in  DW  upstream result sample
- rd_ack  in  1  consumer accepts head entry this cycle
- clr_stat  in  1  clears `ovf`, `min_val` and `max_val`
- rd_data  out  DW  head-of-FIFO sample (show-ahead)
- rd_valid  out  1  FIFO non-empty
- count  out  AW+1  entries held, 0..DEPTH
- full  out  1  count == DEPTH
- ovf  out  1  sticky; a sample was dropped because the FIFO was full
- min_val  out  DW  smallest accepted sample since reset/clear
- max_val  out  DW  largest accepted sample since reset/clear

## Operation
- Storage: DEPTH x DW register array, write pointer `wp` and read pointer `rp` (AW bits, natural wrap), plus `count` (AW+1 bits).
- Write request: `ready`==1 at the rising edge. Read request: `rd_ack`==1 and `rd_valid`==1 at the rising edge. `rd_ack` while empty is ignored.
- Accept write when not full, or when full with a simultaneous read. On accept: mem[wp]<=din, wp<=wp+1.
- Read: rp<=rp+1.
- count: +1 on write only, -1 on read only, unchanged on both or neither.
- Full with write and no read: sample dropped, pointers and count unchanged, ovf<=1.
- Empty with write and `rd_ack`: write accepted, read ignored, count becomes 1.
- rd_data = mem[rp] combinationally from registered state. Undefined content while rd_valid==0; bench must not check it.
- min/max: on each accepted write, min_val<=min(min_val,din) and max_val<=max(max_val,din), unsigned compare. Dropped samples do not update min/max.
- clr_stat: ovf<=0, min_val<=all-ones, max_val<=0. clr_stat has priority over the same-cycle ovf set and min/max update. FIFO contents are untouched.
- States: EMPTY (count 0), PARTIAL, FULL, derived from `count`; no separate FSM register.

## Timing
- Reset (reset==0 at an edge): wp=rp=0, count=0, rd_valid=0, full=0, ovf=0, min_val=all-ones, max_val=0. Memory contents are not reset.
- Reset mid-operation flushes everything above on that edge. `ready`/`rd_ack` in the same cycle are ignored.
- Write latency is 1 edge. A sample accepted at edge k is visible on rd_data/rd_valid and counted after edge k.
- A read at edge k moves rd_data to the next entry after edge k.
- Throughput: one write and one read per cycle sustained, with no bubbles.
- Upstream `ready` goes high on a falling edge and stays high. From then on every rising edge is a write, so the consumer must ack every cycle to avoid overflow.
- All outputs are registered or decoded from registers only; no combinational path from any input to any output.

## Test plan
- Reset with reset=0 for 2 cycles, then release -> count=0, rd_valid=0, full=0, ovf=0, min_val=16'hFFFF, max_val=0.
- Write 5, 9, 3 on consecutive edges with no ack -> count=3, rd_data=5; ack 3 cycles -> rd_data 9 then 3, then rd_valid=0; min_val=3, max_val=9.
- Write 17 samples 0..16 with no ack (DEPTH=16) -> full=1, count=16, ovf=1 after the 17th edge; drain all -> reads 0..15 in order, min_val=0, max_val=15 (16 was dropped and does not update max).
- Fill to full, then ready=1 and rd_ack=1 together for 20 cycles -> count stays 16, ovf stays 0, outputs in strict input order across pointer wrap.
- With ovf=1, assert clr_stat together with a dropped write -> ovf=0, min_val=FFFF, max_val=0 after the edge; count unchanged.
- Assert reset=0 mid-stream with count=7 -> count=0 and rd_valid=0 next cycle; the first write after release appears at rd_data.

Source files
------------

// File: rtl/avg_sink.sv
// avg_sink: result sink for the 12-sample average-nearest filter.
// Captures every sample presented while ready is high into a DEPTH-entry
// circular FIFO and hands it to a consumer via a show-ahead valid/ack port.
// It also tracks sticky overflow and the running unsigned min/max of
// accepted samples.
//
// Ports:
//   clk       in   single clock, rising edge
//   reset     in   synchronous active-low reset
//   ready     in   upstream sample valid (din holds a new result)
//   din       in   upstream sample [DW-1:0]
//   rd_ack    in   consumer takes the head entry (ignored while empty)
//   clr_stat  in   clears ovf, min_val, max_val
//   rd_data   out  head-of-FIFO sample (show-ahead)
//   rd_valid  out  FIFO non-empty
//   count     out  entries held, 0..DEPTH [AW:0]
//   full      out  count == DEPTH
//   ovf       out  sticky: a sample was dropped while full
//   min_val   out  smallest accepted sample since reset/clear
//   max_val   out  largest accepted sample since reset/clear
//
// Occupancy state is decoded from count; there is no separate state register.
//   state   | meaning
//   EMPTY   | count == 0, rd_valid low, ack ignored
//   PARTIAL | 0 < count < DEPTH, writes and reads both accepted
//   FULL    | count == DEPTH, a write without a read is dropped and sets ovf
module avg_sink #(
   parameter int DW    = 16,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ready,
   input  logic [DW-1:0] din,
   input  logic          rd_ack,
   input  logic          clr_stat,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid,
   output logic [AW:0]   count,
   output logic          full,
   output logic          ovf,
   output logic [DW-1:0] min_val,
   output logic [DW-1:0] max_val
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic          do_rd;
   logic          do_wr;
   logic          drop;

   assign rd_valid = (count != '0);
   assign full     = (count == DEPTH_C);
   assign rd_data  = mem[rp];

   // A full FIFO still accepts a write when the head leaves on the same edge.
   assign do_rd = rd_ack & rd_valid;
   assign do_wr = ready & (~full | do_rd);
   assign drop  = ready & ~do_wr;

   // Storage is deliberately not reset; rd_valid gates its use.
   always_ff @(posedge clk) begin
      if (reset && do_wr) begin
         mem[wp] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (do_wr) wp <= wp + 1'b1;
         if (do_rd) rp <= rp + 1'b1;
         if (do_wr && !do_rd)      count <= count + 1'b1;
         else if (do_rd && !do_wr) count <= count - 1'b1;
      end
   end

   // clr_stat wins over a same-edge overflow or min/max update.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ovf     <= 1'b0;
         min_val <= '1;
         max_val <= '0;
      end else if (clr_stat) begin
         ovf     <= 1'b0;
         min_val <= '1;
         max_val <= '0;
      end else begin
         if (drop) ovf <= 1'b1;
         if (do_wr) begin
            if (din < min_val) min_val <= din;
            if (din > max_val) max_val <= din;
         end
      end
   end

endmodule

// File: tb/tb_avg_sink.sv
module tb_avg_sink;

   logic        clk;
   logic        reset;
   logic        ready;
   logic [15:0] din;
   logic        rd_ack;
   logic        clr_stat;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic [4:0]  count;
   logic        full;
   logic        ovf;
   logic [15:0] min_val;
   logic [15:0] max_val;

   int checks   = 0;
   int failures = 0;

   avg_sink #(.DW(16), .DEPTH(16)) dut (
      .clk      (clk),
      .reset    (reset),
      .ready    (ready),
      .din      (din),
      .rd_ack   (rd_ack),
      .clr_stat (clr_stat),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .count    (count),
      .full     (full),
      .ovf      (ovf),
      .min_val  (min_val),
      .max_val  (max_val)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One rising edge, then settle on the falling edge where inputs change.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b0; ready = 1'b0; din = '0; rd_ack = 1'b0; clr_stat = 1'b0;
      @(negedge clk);
      tick(); tick();
      chk("rst_count", 32'(count), 0);
      chk("rst_valid", 32'(rd_valid), 0);
      chk("rst_full", 32'(full), 0);
      chk("rst_ovf", 32'(ovf), 0);
      chk("rst_min", 32'(min_val), 32'hFFFF);
      chk("rst_max", 32'(max_val), 0);
      reset = 1'b1;

      // three writes, then three reads
      ready = 1'b1;
      din = 16'd5; tick();
      din = 16'd9; tick();
      din = 16'd3; tick();
      ready = 1'b0;
      chk("w3_count", 32'(count), 3);
      chk("w3_valid", 32'(rd_valid), 1);
      chk("w3_head", 32'(rd_data), 5);
      rd_ack = 1'b1;
      tick();
      chk("r1_head", 32'(rd_data), 9);
      tick();
      chk("r2_head", 32'(rd_data), 3);
      tick();
      rd_ack = 1'b0;
      chk("r3_valid", 32'(rd_valid), 0);
      chk("r3_count", 32'(count), 0);
      chk("w3_min", 32'(min_val), 3);
      chk("w3_max", 32'(max_val), 9);

      // fresh stats, then overfill with 0..16
      clr_stat = 1'b1; tick(); clr_stat = 1'b0;
      ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         din = 16'(i); tick();
      end
      chk("fill_full", 32'(full), 1);
      chk("fill_ovf_pre", 32'(ovf), 0);
      din = 16'd16; tick();
      ready = 1'b0;
      chk("ovf_set", 32'(ovf), 1);
      chk("ovf_count", 32'(count), 16);
      chk("ovf_full", 32'(full), 1);
      chk("ovf_min", 32'(min_val), 0);
      chk("ovf_max", 32'(max_val), 15);

      // clear together with a dropped write
      ready = 1'b1; din = 16'h1234; clr_stat = 1'b1;
      tick();
      ready = 1'b0; clr_stat = 1'b0;
      chk("clr_ovf", 32'(ovf), 0);
      chk("clr_min", 32'(min_val), 32'hFFFF);
      chk("clr_max", 32'(max_val), 0);
      chk("clr_count", 32'(count), 16);

      rd_ack = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("drain_data", 32'(rd_data), 32'(i));
         tick();
      end
      rd_ack = 1'b0;
      chk("drain_valid", 32'(rd_valid), 0);
      chk("drain_count", 32'(count), 0);

      // full with simultaneous read/write across pointer wrap
      ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         din = 16'(100 + i); tick();
      end
      chk("sus_full", 32'(full), 1);
      rd_ack = 1'b1;
      for (int j = 0; j < 20; j++) begin
         din = 16'(116 + j);
         chk("sus_data", 32'(rd_data), 32'(100 + j));
         tick();
         chk("sus_count", 32'(count), 16);
      end
      ready = 1'b0; rd_ack = 1'b0;
      chk("sus_ovf", 32'(ovf), 0);
      chk("sus_head", 32'(rd_data), 120);
      chk("sus_min", 32'(min_val), 100);
      chk("sus_max", 32'(max_val), 135);

      // bring count to 7, then reset with traffic present
      rd_ack = 1'b1;
      for (int i = 0; i < 9; i++) tick();
      rd_ack = 1'b0;
      chk("pre_rst_count", 32'(count), 7);
      chk("pre_rst_head", 32'(rd_data), 129);
      reset = 1'b0; ready = 1'b1; rd_ack = 1'b1; din = 16'd77;
      tick();
      chk("mid_rst_count", 32'(count), 0);
      chk("mid_rst_valid", 32'(rd_valid), 0);
      chk("mid_rst_min", 32'(min_val), 32'hFFFF);
      chk("mid_rst_max", 32'(max_val), 0);
      reset = 1'b1; rd_ack = 1'b0; din = 16'hABCD;
      tick();
      ready = 1'b0;
      chk("post_rst_head", 32'(rd_data), 32'hABCD);
      chk("post_rst_count", 32'(count), 1);
      chk("post_rst_min", 32'(min_val), 32'hABCD);
      chk("post_rst_max", 32'(max_val), 32'hABCD);

      // empty with write and ack: read ignored
      rd_ack = 1'b1; tick();
      chk("empty_again", 32'(count), 0);
      ready = 1'b1; din = 16'd42;
      tick();
      ready = 1'b0; rd_ack = 1'b0;
      chk("ew_count", 32'(count), 1);
      chk("ew_head", 32'(rd_data), 42);
      chk("ew_valid", 32'(rd_valid), 1);

      // ack while empty does not disturb count
      rd_ack = 1'b1; tick(); tick();
      rd_ack = 1'b0;
      chk("ack_empty_count", 32'(count), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
